// File: rtl/arb_pkg.sv
// Shared types and defaults for the round-robin bus arbiter.
package arb_pkg;

    localparam int unsigned ARB_N_MASTERS = 4;
    localparam int unsigned ARB_MAX_HOLD  = 16;
    localparam int unsigned ARB_OWNER_W   = $clog2(ARB_N_MASTERS);

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_OWNED = 1'b1
    } arb_state_e;

    typedef logic [ARB_OWNER_W-1:0] owner_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after start, wrapping modulo N.
module rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic          valid,
    output logic [IW-1:0] idx
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [IW:0]    sum;

    // Rotate so bit 0 of rot corresponds to the start index.
    assign dbl = {req, req} >> start;
    assign rot = dbl[N-1:0];

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        sum   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                valid = 1'b1;
                sum   = {1'b0, start} + (IW+1)'(k);
                if (sum >= (IW+1)'(N)) begin
                    sum = sum - (IW+1)'(N);
                end
                idx = sum[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with active-low request/grant and MAX_HOLD tenure preemption.
module bus_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned N_MASTERS = ARB_N_MASTERS,
    parameter int unsigned MAX_HOLD  = ARB_MAX_HOLD
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_MASTERS-1:0]         m_req_,
    output logic [N_MASTERS-1:0]         m_grnt_,
    output logic [$clog2(N_MASTERS)-1:0] owner,
    output logic                         bus_busy,
    output logic                         preempt
);

    localparam int unsigned IW = $clog2(N_MASTERS);
    localparam int unsigned CW = $clog2(MAX_HOLD);
    localparam logic [N_MASTERS-1:0] ONE = N_MASTERS'(1);

    arb_state_e          state;
    logic [IW-1:0]       last_owner;
    logic [CW-1:0]       hold_cnt;
    logic [N_MASTERS-1:0] req;
    logic [N_MASTERS-1:0] cand;
    logic [IW-1:0]       start;
    logic [IW-1:0]       pick_idx;
    logic                pick_valid;
    logic                owner_req;
    logic                expired;
    logic                take;

    assign req       = ~m_req_;
    assign owner_req = req[owner];
    assign expired   = (hold_cnt == CW'(MAX_HOLD - 1));
    assign start     = (last_owner == IW'(N_MASTERS - 1)) ? '0 : last_owner + IW'(1);
    // While owned the current owner is excluded so a release or preemption always moves on.
    assign cand      = (state == ARB_OWNED) ? (req & ~(ONE << owner)) : req;
    assign bus_busy  = ~&m_grnt_;

    rr_pick #(
        .N  (N_MASTERS),
        .IW (IW)
    ) u_rr_pick (
        .req   (cand),
        .start (start),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        take = 1'b0;
        if (state == ARB_IDLE) begin
            take = pick_valid;
        end else if (!owner_req || expired) begin
            take = pick_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ARB_IDLE;
            m_grnt_    <= '1;
            owner      <= '0;
            hold_cnt   <= '0;
            last_owner <= IW'(N_MASTERS - 1);
            preempt    <= 1'b0;
        end else begin
            preempt <= 1'b0;
            if (take) begin
                state      <= ARB_OWNED;
                m_grnt_    <= ~(ONE << pick_idx);
                owner      <= pick_idx;
                last_owner <= pick_idx;
                hold_cnt   <= '0;
                preempt    <= (state == ARB_OWNED) && owner_req;
            end else if (state == ARB_OWNED && !owner_req) begin
                state   <= ARB_IDLE;
                m_grnt_ <= '1;
            end else if (state == ARB_OWNED && !expired) begin
                hold_cnt <= hold_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: vector table plus preemption and rotation sequences.
module tb_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req, req2;
    logic [3:0] grnt, grnt2;
    logic [1:0] own, own2;
    logic       busy, busy2, pre, pre2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    bus_arbiter #(.N_MASTERS(4), .MAX_HOLD(16)) dut (
        .clk(clk), .rst(rst), .m_req_(req), .m_grnt_(grnt),
        .owner(own), .bus_busy(busy), .preempt(pre)
    );

    bus_arbiter #(.N_MASTERS(4), .MAX_HOLD(2)) dut2 (
        .clk(clk), .rst(rst), .m_req_(req2), .m_grnt_(grnt2),
        .owner(own2), .bus_busy(busy2), .preempt(pre2)
    );

    // At most one grant low on either instance, every cycle.
    always @(negedge clk) begin
        assert ($countones(~grnt) <= 1 && $countones(~grnt2) <= 1)
        else begin
            $display("FAIL onehot grnt=%b grnt2=%b", grnt, grnt2);
            n_fail++;
        end
    end

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] grnt;
        logic [1:0] own;
        logic       busy;
        logic       pre;
        logic       chk_own;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    int tenure;
    int pre_cnt;
    int bad;
    int exp_own[10];

    initial begin
        rst  = 1'b1;
        req  = 4'b1111;
        req2 = 4'b1111;

        vecs[0]  = '{1'b1, 4'b1111, 4'b1111, 2'd0, 1'b0, 1'b0, 1'b1};
        vecs[1]  = '{1'b0, 4'b1110, 4'b1110, 2'd0, 1'b1, 1'b0, 1'b1};
        vecs[2]  = '{1'b0, 4'b1110, 4'b1110, 2'd0, 1'b1, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, 4'b0101, 4'b1101, 2'd1, 1'b1, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 4'b0101, 4'b1101, 2'd1, 1'b1, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 4'b0111, 4'b0111, 2'd3, 1'b1, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 4'b1111, 4'b1111, 2'd0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 4'b1111, 4'b1111, 2'd0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 4'b0000, 4'b1110, 2'd0, 1'b1, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 4'b0001, 4'b1101, 2'd1, 1'b1, 1'b0, 1'b1};
        vecs[10] = '{1'b1, 4'b0000, 4'b1111, 2'd0, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 4'b0000, 4'b1110, 2'd0, 1'b1, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 4'b1010, 4'b1110, 2'd0, 1'b1, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 4'b1011, 4'b1011, 2'd2, 1'b1, 1'b0, 1'b1};

        for (int i = 0; i < 14; i++) begin
            rst = vecs[i].rst;
            req = vecs[i].req;
            cyc();
            chk($sformatf("vec%0d grnt", i), int'(grnt), int'(vecs[i].grnt));
            chk($sformatf("vec%0d busy", i), int'(busy), int'(vecs[i].busy));
            chk($sformatf("vec%0d preempt", i), int'(pre), int'(vecs[i].pre));
            if (vecs[i].chk_own) begin
                chk($sformatf("vec%0d owner", i), int'(own), int'(vecs[i].own));
            end
        end

        // Master 2 holds with master 0 waiting: 16-cycle tenure then one preempt.
        req = 4'b1111;
        do_reset();
        req = 4'b1011;
        cyc();
        chk("hold first grant", int'(grnt), int'(4'b1011));
        tenure  = 1;
        pre_cnt = 0;
        req = 4'b1010;
        for (int i = 1; i < 20; i++) begin
            cyc();
            if (grnt == 4'b1011 && pre_cnt == 0) tenure++;
            if (pre) begin
                pre_cnt++;
                chk("preempt new grant", int'(grnt), int'(4'b1110));
            end
        end
        chk("hold tenure", tenure, 16);
        chk("hold preempt count", pre_cnt, 1);
        chk("hold final owner", int'(own), 0);

        // Sole requester keeps the bus indefinitely.
        req = 4'b1111;
        do_reset();
        req = 4'b1011;
        bad     = 0;
        pre_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (grnt != 4'b1011) bad++;
            if (pre) pre_cnt++;
        end
        chk("sole grant lost cycles", bad, 0);
        chk("sole preempt count", pre_cnt, 0);

        // MAX_HOLD=2 with everyone requesting rotates 0,0,1,1,2,2,3,3,0,0.
        req  = 4'b1111;
        do_reset();
        req2 = 4'b0000;
        exp_own = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk($sformatf("rot%0d owner", i), int'(own2), exp_own[i]);
            chk($sformatf("rot%0d busy", i), int'(busy2), 1);
            chk($sformatf("rot%0d preempt", i), int'(pre2),
                (i > 0 && exp_own[i] != exp_own[i-1]) ? 1 : 0);
        end
        req2 = 4'b1111;
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter: N_MASTERS, 4, number of bus masters (2..8).
REQ-002 Parameter: MAX_HOLD, 16, maximum grant tenure in cycles before forced rotation when others wait (2..255).
REQ-003 Port: clk  input  1  system clock; all logic on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: m_req_  input  N_MASTERS  per-master bus request, active-low.
REQ-006 Port: m_grnt_  output  N_MASTERS  per-master bus grant, active-low, registered, at most one low.
REQ-007 Port: owner  output  clog2(N_MASTERS)  index of current grant holder; valid only while bus_busy high.
REQ-008 Port: bus_busy  output  1  high while any grant is asserted.
REQ-009 Port: preempt  output  1  one-cycle pulse on the edge where a grant was revoked by MAX_HOLD expiry.

Function
REQ-010 The block SHALL implement a two-state FSM: IDLE (no grant) and OWNED (one grant asserted).
REQ-011 In IDLE with any m_req_ low, the block SHALL grant, on the next edge, the first requester searching round-robin from last_owner+1 modulo N_MASTERS.
REQ-012 Grant latency from request to m_grnt_ low SHALL be exactly one cycle when the bus is IDLE.
REQ-013 In OWNED, the grant SHALL persist while the owner's m_req_ stays low and the hold count is below MAX_HOLD-1.
REQ-014 When the owner raises m_req_, the block SHALL, on the next edge, either grant the next round-robin requester (skipping the old owner) or enter IDLE if none; no idle gap cycle is inserted between owners.
REQ-015 A hold counter SHALL clear on every new grant and increment each OWNED cycle, saturating at MAX_HOLD-1.
REQ-016 When the counter equals MAX_HOLD-1 and at least one other master requests, the block SHALL revoke the grant and grant the next round-robin requester on the next edge, pulsing preempt for that cycle.
REQ-017 When the counter equals MAX_HOLD-1 and no other master requests, the owner SHALL keep the grant; preempt stays low.
REQ-018 A preempted master keeping m_req_ low SHALL be re-queued at the lowest round-robin priority.
REQ-019 last_owner SHALL update on every grant and retain its value through IDLE.
REQ-020 Simultaneous owner release and other requests SHALL resolve purely by round-robin order from owner+1.
REQ-021 Requests from a master index >= N_MASTERS do not exist; counter and owner arithmetic SHALL wrap modulo N_MASTERS without out-of-range values.
REQ-022 bus_busy SHALL equal the OR of inverted m_grnt_ bits and SHALL be driven from registered state only.

Reset
REQ-023 On rst high at a clock edge, the block SHALL enter IDLE, drive m_grnt_ all-ones, owner 0, bus_busy 0, preempt 0, hold counter 0, last_owner N_MASTERS-1 (so master 0 wins first).
REQ-024 Reset asserted during OWNED SHALL drop the grant on that edge regardless of m_req_.
REQ-025 The first grant after reset release SHALL occur no earlier than one cycle after rst falls.

Structure
REQ-026 Package arb_pkg SHALL hold the FSM state enum (ARB_IDLE, ARB_OWNED), default N_MASTERS and MAX_HOLD constants, and the owner index typedef.
REQ-027 Round-robin selection SHALL be one combinational sub-module, rr_pick (inputs: request vector, start index; outputs: valid, index), instanced once.
REQ-028 The FSM, hold counter, and grant register SHALL live in bus_arbiter; no other sub-modules.

Verification
REQ-029 Reset then m_req_=4'b1110 -> cycle+1 m_grnt_=4'b1110, owner=0, bus_busy=1.
REQ-030 Masters 1 and 3 request together after owner 0 releases -> grant master 1 next edge, master 3 after master 1 releases, no idle gap.
REQ-031 Master 2 holds request 20 cycles with master 0 requesting, MAX_HOLD=16 -> grant moves to master 0 after 16 OWNED cycles, preempt pulses exactly once.
REQ-032 Master 2 sole requester for 40 cycles -> grant stays continuously, preempt never asserts.
REQ-033 rst asserted while master 1 owns -> m_grnt_=4'b1111, bus_busy=0 that edge; after release with m_req_=4'b0000, master 0 granted first.
REQ-034 All masters request continuously, MAX_HOLD=2 -> grant sequence 0,1,2,3,0 with each tenure 2 cycles; assertion check: at most one m_grnt_ bit low every cycle.
